cla_word_sequencer: RTL and testbench

- Multi-cycle controller that drives one shared external 16-bit CLA adder (CLA16-style port set: A, B, Ci in; S, Co out) to perform WORDS×W-bit add/subtract, one W-bit word per cycle, least significant word first.
- The carry is registered between words.
- Sits in the FPU datapath beside the adder instance and presents valid/ready handshakes to the requesting unit.

---
 rtl/cla_word_sequencer.sv | 110 +++++++++++
 tb/tb_cla_word_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_sequencer.sv
// Purpose: drives one shared external W-bit CLA adder to do a WORDS*W-bit add/sub, one word per cycle, LS word first.
// Latency: out_valid rises WORDS cycles after the accept edge; the carry is registered between words.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready, and abort drops it.
module cla_word_sequencer #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] in_a,
    input  logic [W*WORDS-1:0] in_b,
    input  logic               in_sub,
    input  logic               in_ci,
    input  logic               abort,
    output logic [W-1:0]       adder_a,
    output logic [W-1:0]       adder_b,
    output logic               adder_ci,
    input  logic [W-1:0]       adder_s,
    input  logic               adder_co,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] out_sum,
    output logic               out_co,
    output logic               out_ovf
);
    localparam int OPW   = W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_r;
    logic [OPW-1:0]   a_r;
    logic [OPW-1:0]   b_r;      // holds ~in_b for subtract
    logic [OPW-1:0]   sum_r;
    logic             co_r;
    logic             ovf_r;

    // Handshake flags decode registered state only; no path from in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_r;
    assign out_co    = co_r;
    assign out_ovf   = ovf_r;

    // Feed the current word to the adder during RUN; hold its inputs at zero otherwise.
    always_comb begin
        adder_a  = '0;
        adder_b  = '0;
        adder_ci = 1'b0;
        if (state == RUN) begin
            adder_a  = a_r[W*int'(idx) +: W];
            adder_b  = b_r[W*int'(idx) +: W];
            adder_ci = carry_r;
        end
    end

    // Sequencer: accept, step one word per cycle capturing the adder return, hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (abort) begin
            // Partial result is left in sum_r; out_valid alone tells the consumer it is not valid.
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_sub ? ~in_b : in_b;
                        carry_r <= in_sub ? ~in_ci : in_ci;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_r[W*int'(idx) +: W] <= adder_s;
                    carry_r                 <= adder_co;
                    if (idx == LAST_IDX) begin
                        // Last word: adder_s[W-1] is the MSB of the full-width result.
                        co_r  <= adder_co;
                        ovf_r <= (a_r[OPW-1] == b_r[OPW-1]) && (adder_s[W-1] != a_r[OPW-1]);
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer with W=16, WORDS=4 and a behavioural 16-bit adder.
// Expected results come from a full-width reference model pushed to a scoreboard queue.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_cla_word_sequencer;
    localparam int W     = 16;
    localparam int WORDS = 4;

    typedef struct packed {
        logic [63:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_sub;
    logic        in_ci;
    logic        abort;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic        adder_ci;
    logic [15:0] adder_s;
    logic        adder_co;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_co;
    logic        out_ovf;

    int   checks;
    int   failures;
    exp_t sb[$];

    cla_word_sequencer #(.W(W), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_ci(in_ci),
        .abort(abort),
        .adder_a(adder_a), .adder_b(adder_b), .adder_ci(adder_ci),
        .adder_s(adder_s), .adder_co(adder_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf)
    );

    // External 16-bit adder
    assign {adder_co, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s, input logic c);
        logic [63:0] be;
        logic [64:0] f;
        exp_t        e;
        be    = s ? ~b : b;
        f     = {1'b0, a} + {1'b0, be} + {64'd0, (s ? ~c : c)};
        e.sum = f[63:0];
        e.co  = f[64];
        e.ovf = (a[63] == be[63]) && (f[63] != a[63]);
        return e;
    endfunction

    // Drive one op from IDLE, record adder_ci per word, wait (bounded) for the result, consume it.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic c,
                          output logic [63:0] sum, output logic co, output logic ovf,
                          output int lat, output logic [3:0] cis);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = s; in_ci = c; in_valid = 1'b1;
        sb.push_back(model(a, b, s, c));
        @(negedge clk);
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_ci = 1'b0;
        lat = 0;
        cis = '0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) cis[lat] = adder_ci;
            lat++;
            @(negedge clk);
        end
        sum = out_sum; co = out_co; ovf = out_ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_ci = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_sum, out_co, out_ovf} !== 66'd0) begin failures++; $display("FAIL reset_outputs got=%h/%b/%b exp=0", out_sum, out_co, out_ovf); end
        checks++; if ({adder_a, adder_b, adder_ci} !== 33'd0) begin failures++; $display("FAIL reset_adder_drive got=%h/%h/%b exp=0", adder_a, adder_b, adder_ci); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_carry();
        logic [63:0] s; logic co, ov; int lat; logic [3:0] cis; exp_t e;
        run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, s, co, ov, lat, cis);
        e = sb.pop_front();
        checks++; if (s !== e.sum) begin failures++; $display("FAIL carry_sum got=%h exp=%h", s, e.sum); end
        checks++; if (s !== 64'h0000_0000_0001_0000) begin failures++; $display("FAIL carry_sum_const got=%h exp=0000000000010000", s); end
        checks++; if ({co, ov} !== {e.co, e.ovf}) begin failures++; $display("FAIL carry_co_ovf got=%b%b exp=%b%b", co, ov, e.co, e.ovf); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL carry_latency got=%0d exp=4", lat); end
        checks++; if (cis !== 4'b0010) begin failures++; $display("FAIL carry_ci_seq got=%b exp=0010 (idx3..idx0)", cis); end
    endtask

    task automatic test_wrap();
        logic [63:0] s; logic co, ov; int lat; logic [3:0] cis; exp_t e;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, s, co, ov, lat, cis);
        e = sb.pop_front();
        checks++; if (s !== e.sum) begin failures++; $display("FAIL wrap_sum got=%h exp=%h", s, e.sum); end
        checks++; if ({co, ov} !== 2'b10) begin failures++; $display("FAIL wrap_co_ovf got=%b%b exp=10", co, ov); end
        checks++; if (cis !== 4'b1110) begin failures++; $display("FAIL wrap_ci_seq got=%b exp=1110", cis); end
    endtask

    task automatic test_sub();
        logic [63:0] s; logic co, ov; int lat; logic [3:0] cis; exp_t e;
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, s, co, ov, lat, cis);
        e = sb.pop_front();
        checks++; if (s !== e.sum) begin failures++; $display("FAIL sub_ovf_sum got=%h exp=%h", s, e.sum); end
        checks++; if (s !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sub_ovf_sum_const got=%h exp=7fffffffffffffff", s); end
        checks++; if ({co, ov} !== 2'b11) begin failures++; $display("FAIL sub_ovf_co_ovf got=%b%b exp=11", co, ov); end
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, s, co, ov, lat, cis);
        e = sb.pop_front();
        checks++; if (s !== 64'd0) begin failures++; $display("FAIL sub_eq_sum got=%h exp=0", s); end
        checks++; if ({co, ov} !== {e.co, e.ovf} || {co, ov} !== 2'b10) begin failures++; $display("FAIL sub_eq_co_ovf got=%b%b exp=10", co, ov); end
        // A few random add/sub ops against the reference model
        for (int i = 0; i < 6; i++) begin
            logic [63:0] ra, rb;
            logic        rs, rc;
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            rs = 1'($urandom_range(1)); rc = 1'($urandom_range(1));
            run_op(ra, rb, rs, rc, s, co, ov, lat, cis);
            e = sb.pop_front();
            checks++; if ({s, co, ov} !== {e.sum, e.co, e.ovf}) begin failures++; $display("FAIL random_op%0d got=%h/%b/%b exp=%h/%b/%b", i, s, co, ov, e.sum, e.co, e.ovf); end
        end
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        int   n;
        logic ok;
        @(negedge clk);
        in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321; in_sub = 1'b0; in_ci = 1'b1; in_valid = 1'b1;
        sb.push_back(model(in_a, in_b, in_sub, in_ci));
        @(negedge clk);
        in_a = 64'd1000; in_b = 64'd1; in_sub = 1'b1; in_ci = 1'b0;  // held valid while busy
        sb.push_back(model(in_a, in_b, in_sub, in_ci));
        e1 = sb.pop_front();
        n = 0;
        while (!out_valid && n < 20) begin n++; @(negedge clk); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
        checks++; if ({out_sum, out_co, out_ovf} !== {e1.sum, e1.co, e1.ovf}) begin failures++; $display("FAIL bp_first_result got=%h/%b/%b exp=%h/%b/%b", out_sum, out_co, out_ovf, e1.sum, e1.co, e1.ovf); end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_sum, out_co, out_ovf} !== {e1.sum, e1.co, e1.ovf}) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_hold got=unstable exp=stable result, in_ready=0 (now %h/%b/%b)", out_sum, out_valid, in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL bp_idle_after_consume got=%b%b exp=10", in_ready, out_valid); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_second_accept got in_ready=%b exp=0", in_ready); end
        in_valid = 1'b0;
        e2 = sb.pop_front();
        n = 0;
        while (!out_valid && n < 20) begin n++; @(negedge clk); end
        checks++; if ({out_valid, out_sum, out_co, out_ovf} !== {1'b1, e2.sum, e2.co, e2.ovf}) begin failures++; $display("FAIL bp_second_result got=%b/%h/%b/%b exp=1/%h/%b/%b", out_valid, out_sum, out_co, out_ovf, e2.sum, e2.co, e2.ovf); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic [63:0] s; logic co, ov; int lat; logic [3:0] cis; exp_t e;
        logic seen;
        @(negedge clk);
        in_a = 64'h0001_0002_0003_0004; in_b = 64'h0005_0006_0007_0008; in_sub = 1'b0; in_ci = 1'b0; in_valid = 1'b1;
        @(negedge clk);  // RUN idx0
        in_valid = 1'b0;
        @(negedge clk);  // idx1
        @(negedge clk);  // idx2
        checks++; if (adder_a !== 16'h0002) begin failures++; $display("FAIL abort_at_idx2 adder_a got=%h exp=0002", adder_a); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL abort_to_idle got=%b%b exp=10", in_ready, out_valid); end
        checks++; if ({adder_a, adder_b, adder_ci} !== 33'd0) begin failures++; $display("FAIL abort_adder_drive got=%h/%h/%b exp=0", adder_a, adder_b, adder_ci); end
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_valid got=valid seen exp=none"); end
        // abort wins over a request in IDLE
        in_valid = 1'b1; abort = 1'b1; in_a = 64'd9; in_b = 64'd9;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_idle_no_accept got in_ready=%b exp=1", in_ready); end
        run_op(64'd5, 64'd7, 1'b0, 1'b0, s, co, ov, lat, cis);
        e = sb.pop_front();
        checks++; if (s !== 64'd12 || s !== e.sum) begin failures++; $display("FAIL abort_next_op got=%h exp=%h", s, 64'd12); end
    endtask

    task automatic test_async_reset();
        int n;
        // mid-RUN
        @(negedge clk);
        in_a = 64'h1111_1111_1111_1111; in_b = 64'h2222_2222_2222_2222; in_sub = 1'b0; in_ci = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_sum[15:0] !== 16'h3333) begin failures++; $display("FAIL arst_run_partial got=%h exp=3333", out_sum[15:0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_sum, out_co, out_ovf} !== 67'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_run got=%b/%h/%b/%b rdy=%b exp=0/0/0/0 rdy=1", out_valid, out_sum, out_co, out_ovf, in_ready); end
        checks++; if ({adder_a, adder_b, adder_ci} !== 33'd0) begin failures++; $display("FAIL arst_run_adder got=%h/%h/%b exp=0", adder_a, adder_b, adder_ci); end
        @(negedge clk);
        rst_n = 1'b1;
        // mid-DONE
        @(negedge clk);
        in_a = 64'h8000_0000_0000_0000; in_b = 64'd1; in_sub = 1'b1; in_ci = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin n++; @(negedge clk); end
        checks++; if ({out_valid, out_co, out_ovf} !== 3'b111) begin failures++; $display("FAIL arst_done_pre got=%b%b%b exp=111", out_valid, out_co, out_ovf); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_sum, out_co, out_ovf} !== 67'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_done got=%b/%h/%b/%b rdy=%b exp=0/0/0/0 rdy=1", out_valid, out_sum, out_co, out_ovf, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_carry();
        test_wrap();
        test_sub();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
